// File: rtl/host_pkg.sv
// Shared definitions for the host arbiter: command/reply bytes, FSM states,
// mux owner encodings and the command decoder.
package host_pkg;

  localparam logic [7:0] CMD_LOAD_INSTR = 8'h1C;
  localparam logic [7:0] CMD_LOAD_DATA  = 8'h1D;
  localparam logic [7:0] CMD_DUMP       = 8'hD0;
  localparam logic [7:0] CMD_RUN        = 8'hC0;
  localparam logic [7:0] CMD_STEP       = 8'hC5;
  localparam logic [7:0] CMD_HALT       = 8'hF0;

  localparam logic [7:0] RPL_ACK     = 8'hA5;
  localparam logic [7:0] RPL_NACK    = 8'hEE;
  localparam logic [7:0] RPL_TIMEOUT = 8'hE7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_SEND_REPLY,
    S_WAIT_TX,
    S_GRANT_LOADER,
    S_GRANT_DUMPER,
    S_RELEASE,
    S_RUN,
    S_STEP
  } state_e;

  typedef enum logic [1:0] {
    TX_OWN_ARB    = 2'd0,
    TX_OWN_LOADER = 2'd1,
    TX_OWN_DUMPER = 2'd2
  } tx_owner_e;

  typedef enum logic [1:0] {
    MEM_OWN_CPU    = 2'd0,
    MEM_OWN_LOADER = 2'd1,
    MEM_OWN_DUMPER = 2'd2
  } mem_owner_e;

  typedef struct packed {
    logic   known;
    state_e target;
  } cmd_decode_t;

  function automatic cmd_decode_t decode_cmd(input logic [7:0] cmd);
    cmd_decode_t d;
    d.known  = 1'b1;
    d.target = S_IDLE;
    case (cmd)
      CMD_LOAD_INSTR, CMD_LOAD_DATA: d.target = S_GRANT_LOADER;
      CMD_DUMP:                      d.target = S_GRANT_DUMPER;
      CMD_RUN:                       d.target = S_RUN;
      CMD_STEP:                      d.target = S_STEP;
      CMD_HALT:                      d.target = S_IDLE;
      default:                       d.known  = 1'b0;
    endcase
    return d;
  endfunction

  // The memory port follows whichever unit owns the UART during a release.
  function automatic mem_owner_e mem_owner_of(input tx_owner_e owner);
    mem_owner_e m;
    case (owner)
      TX_OWN_LOADER: m = MEM_OWN_LOADER;
      TX_OWN_DUMPER: m = MEM_OWN_DUMPER;
      default:       m = MEM_OWN_CPU;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/grant_watchdog.sv
// Grant timeout counter: held at zero while cleared, counts granted cycles,
// flags expiry on the last permitted cycle of a grant.
module grant_watchdog #(
  parameter int unsigned          CNT_W          = 24,
  parameter logic [CNT_W-1:0]     TIMEOUT_CYCLES = CNT_W'(10_000_000)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = TIMEOUT_CYCLES - CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/host_arbiter.sv
// Host-side command arbiter: decodes UART commands, replies, and hands the UART
// and memory port to the loader or dumper under a grant timeout.
module host_arbiter
  import host_pkg::*;
#(
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_done_i,
  output logic [1:0] tx_sel_o,
  output logic [1:0] mem_sel_o,
  output logic       loader_grant_o,
  output logic       loader_target_o,
  input  logic       loader_done_i,
  output logic       dumper_grant_o,
  input  logic       dumper_done_i,
  output logic       cpu_stall_o
);

  state_e      state_d, state_q;
  state_e      target_d, target_q;
  logic [7:0]  cmd_d, cmd_q;
  logic [7:0]  reply_d, reply_q;
  tx_owner_e   owner_d, owner_q;

  cmd_decode_t dec;
  logic        owner_done;
  logic        in_grant;
  logic        wd_expired;
  tx_owner_e   tx_sel;
  mem_owner_e  mem_sel;

  assign in_grant = (state_q == S_GRANT_LOADER) || (state_q == S_GRANT_DUMPER);

  grant_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (!in_grant),
    .enable_i  (in_grant),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      target_q <= S_IDLE;
      cmd_q    <= '0;
      reply_q  <= '0;
      owner_q  <= TX_OWN_ARB;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cmd_q    <= cmd_d;
      reply_q  <= reply_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cmd_d      = cmd_q;
    reply_d    = reply_q;
    owner_d    = owner_q;
    dec        = decode_cmd(cmd_q);
    owner_done = (owner_q == TX_OWN_LOADER) ? loader_done_i : dumper_done_i;

    unique case (state_q)
      S_IDLE: begin
        if (rx_ready_i) begin
          cmd_d   = rx_data_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        reply_d  = dec.known ? RPL_ACK : RPL_NACK;
        target_d = dec.known ? dec.target : S_IDLE;
        state_d  = S_SEND_REPLY;
      end
      S_SEND_REPLY: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done_i) begin
          state_d = target_q;
        end
      end
      // Done is checked first so it wins over a coincident expiry.
      S_GRANT_LOADER: begin
        if (loader_done_i) begin
          owner_d = TX_OWN_LOADER;
          state_d = S_RELEASE;
        end else if (wd_expired) begin
          reply_d  = RPL_TIMEOUT;
          target_d = S_IDLE;
          state_d  = S_SEND_REPLY;
        end
      end
      S_GRANT_DUMPER: begin
        if (dumper_done_i) begin
          owner_d = TX_OWN_DUMPER;
          state_d = S_RELEASE;
        end else if (wd_expired) begin
          reply_d  = RPL_TIMEOUT;
          target_d = S_IDLE;
          state_d  = S_SEND_REPLY;
        end
      end
      S_RELEASE: begin
        if (!owner_done) begin
          owner_d = TX_OWN_ARB;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (rx_ready_i && (rx_data_i == CMD_HALT)) begin
          reply_d  = RPL_ACK;
          target_d = S_IDLE;
          state_d  = S_SEND_REPLY;
        end
      end
      S_STEP: begin
        reply_d  = RPL_ACK;
        target_d = S_IDLE;
        state_d  = S_SEND_REPLY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o     = 1'b1;
    loader_grant_o  = 1'b0;
    loader_target_o = 1'b0;
    dumper_grant_o  = 1'b0;
    tx_start_o      = 1'b0;
    tx_sel          = TX_OWN_ARB;
    mem_sel         = MEM_OWN_CPU;

    case (state_q)
      S_SEND_REPLY: tx_start_o = 1'b1;
      S_GRANT_LOADER: begin
        loader_grant_o  = 1'b1;
        loader_target_o = cmd_q[0];
        tx_sel          = TX_OWN_LOADER;
        mem_sel         = MEM_OWN_LOADER;
      end
      S_GRANT_DUMPER: begin
        dumper_grant_o = 1'b1;
        tx_sel         = TX_OWN_DUMPER;
        mem_sel        = MEM_OWN_DUMPER;
      end
      S_RELEASE: begin
        tx_sel  = owner_q;
        mem_sel = mem_owner_of(owner_q);
      end
      S_RUN, S_STEP: cpu_stall_o = 1'b0;
      default: ;
    endcase
  end

  assign tx_sel_o  = tx_sel;
  assign mem_sel_o = mem_sel;
  assign tx_data_o = reply_q;

endmodule

// File: tb/tb_host_arbiter.sv
// Directed bench for host_arbiter: command table plus hand-written sequences
// for run/halt, step, timeout, done-vs-timeout and mid-grant reset.
module tb_host_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       loader_done = 1'b0;
  logic       dumper_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [1:0] tx_sel;
  logic [1:0] mem_sel;
  logic       loader_grant;
  logic       loader_target;
  logic       dumper_grant;
  logic       cpu_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] reply;
    logic       ld_grant;
    logic       ld_target;
    logic       dp_grant;
    logic [1:0] tx_sel;
    logic [1:0] mem_sel;
    logic       stall;
  } vec_t;

  vec_t vecs[7];

  host_arbiter #(
    .CNT_W          (24),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_data_i       (rx_data),
    .rx_ready_i      (rx_ready),
    .tx_data_o       (tx_data),
    .tx_start_o      (tx_start),
    .tx_done_i       (tx_done),
    .tx_sel_o        (tx_sel),
    .mem_sel_o       (mem_sel),
    .loader_grant_o  (loader_grant),
    .loader_target_o (loader_target),
    .loader_done_i   (loader_done),
    .dumper_grant_o  (dumper_grant),
    .dumper_done_i   (dumper_done),
    .cpu_stall_o     (cpu_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one byte on rx for a single clock; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic expectReply(input string name, input logic [7:0] exp);
    int n = 0;
    while (!tx_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, " tx_start"}, 32'(tx_start), 32'd1);
    if (tx_start) begin
      checkOutput({name, " reply"}, 32'(tx_data), 32'(exp));
      @(posedge clk); #1;
      checkOutput({name, " one-cycle pulse"}, 32'(tx_start), 32'd0);
      checkOutput({name, " data hold"}, 32'(tx_data), 32'(exp));
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
  endtask

  task automatic checkNoReply(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (tx_start) seen++;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " stall"}, 32'(cpu_stall), 32'd1);
    checkOutput({name, " grants"}, {30'd0, loader_grant, dumper_grant}, 32'd0);
    checkOutput({name, " tx_sel"}, 32'(tx_sel), 32'd0);
    checkOutput({name, " mem_sel"}, 32'(mem_sel), 32'd0);
  endtask

  initial begin
    int n;
    int low;
    string nm;

    vecs[0] = '{8'h1C, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1};
    vecs[1] = '{8'h1D, 8'hA5, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1};
    vecs[2] = '{8'hD0, 8'hA5, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1};
    vecs[3] = '{8'h55, 8'hEE, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[4] = '{8'hF0, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[5] = '{8'h00, 8'hEE, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[6] = '{8'hC4, 8'hEE, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};

    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset loader_target", 32'(loader_target), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    checkNoReply("reset exit no reply", 4);

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("vec%0d rx=%02h", i, vecs[i].rx);
      applyStimulus(vecs[i].rx);
      expectReply(nm, vecs[i].reply);
      checkOutput({nm, " loader_grant"}, 32'(loader_grant), 32'(vecs[i].ld_grant));
      checkOutput({nm, " loader_target"}, 32'(loader_target), 32'(vecs[i].ld_target));
      checkOutput({nm, " dumper_grant"}, 32'(dumper_grant), 32'(vecs[i].dp_grant));
      checkOutput({nm, " tx_sel"}, 32'(tx_sel), 32'(vecs[i].tx_sel));
      checkOutput({nm, " mem_sel"}, 32'(mem_sel), 32'(vecs[i].mem_sel));
      checkOutput({nm, " stall"}, 32'(cpu_stall), 32'(vecs[i].stall));
      if (vecs[i].ld_grant) begin
        applyStimulus(8'hF0);
        checkNoReply({nm, " rx ignored in grant"}, 3);
        checkOutput({nm, " grant kept"}, 32'(loader_grant), 32'd1);
        checkOutput({nm, " target stable"}, 32'(loader_target), 32'(vecs[i].ld_target));
      end
      if (vecs[i].ld_grant || vecs[i].dp_grant) begin
        loader_done = vecs[i].ld_grant;
        dumper_done = vecs[i].dp_grant;
        @(posedge clk); #1;
        checkOutput({nm, " release grants"}, {30'd0, loader_grant, dumper_grant}, 32'd0);
        checkOutput({nm, " release tx_sel"}, 32'(tx_sel), 32'(vecs[i].tx_sel));
        checkOutput({nm, " release mem_sel"}, 32'(mem_sel), 32'(vecs[i].mem_sel));
        @(posedge clk); #1;
        checkOutput({nm, " release holds while done"}, 32'(tx_sel), 32'(vecs[i].tx_sel));
        loader_done = 1'b0;
        dumper_done = 1'b0;
        @(posedge clk); #1;
        checkIdle({nm, " after release"});
      end
    end

    applyStimulus(8'hC0);
    expectReply("run", 8'hA5);
    checkOutput("run stall", 32'(cpu_stall), 32'd0);
    checkOutput("run mem_sel", 32'(mem_sel), 32'd0);
    applyStimulus(8'hD0);
    checkNoReply("run discards dump", 3);
    checkOutput("run still running", 32'(cpu_stall), 32'd0);
    checkOutput("run no dumper grant", 32'(dumper_grant), 32'd0);
    applyStimulus(8'hF0);
    checkOutput("halt stall next edge", 32'(cpu_stall), 32'd1);
    expectReply("halt", 8'hA5);
    checkIdle("after halt");

    applyStimulus(8'hC5);
    expectReply("step ack", 8'hA5);
    low = 0;
    if (!cpu_stall) low++;
    @(posedge clk); #1;
    if (!cpu_stall) low++;
    checkOutput("step low cycles", 32'(low), 32'd1);
    expectReply("step done", 8'hA5);
    checkIdle("after step");

    applyStimulus(8'hD0);
    expectReply("timeout ack", 8'hA5);
    n = 0;
    while (dumper_grant && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("timeout grant cycles", 32'(n), 32'd16);
    expectReply("timeout reply", 8'hE7);
    checkIdle("after timeout");

    applyStimulus(8'h1C);
    expectReply("coincide ack", 8'hA5);
    repeat (15) begin
      @(posedge clk); #1;
    end
    checkOutput("coincide grant at last cycle", 32'(loader_grant), 32'd1);
    loader_done = 1'b1;
    @(posedge clk); #1;
    checkOutput("coincide grant dropped", 32'(loader_grant), 32'd0);
    checkOutput("coincide no timeout reply", 32'(tx_start), 32'd0);
    checkOutput("coincide release tx_sel", 32'(tx_sel), 32'd1);
    loader_done = 1'b0;
    @(posedge clk); #1;
    checkIdle("coincide idle");
    checkNoReply("coincide silent", 3);

    applyStimulus(8'h1D);
    expectReply("reset grant ack", 8'hA5);
    checkOutput("reset grant held", 32'(loader_grant), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("mid-grant reset");
    checkOutput("mid-grant reset target", 32'(loader_target), 32'd0);
    checkOutput("mid-grant reset tx_data", 32'(tx_data), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    checkNoReply("mid-grant reset exit no reply", 4);
    checkIdle("after mid-grant reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/host_arbiter.md
HOST_ARBITER -- requirements
Module: host_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd10_000_000: maximum cycles a unit may hold a grant before revocation.
REQ-002 Parameter CNT_W, default 24: width of the timeout counter.
REQ-003 clk_i  in  1  single system clock, all logic on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 rx_data_i  in  8  received UART byte, broadcast to all units.
REQ-006 rx_ready_i  in  1  one-cycle strobe, rx_data_i valid.
REQ-007 tx_data_o  out  8  arbiter-owned TX byte.
REQ-008 tx_start_o  out  1  one-cycle TX launch pulse.
REQ-009 tx_done_i  in  1  TX byte complete.
REQ-010 tx_sel_o  out  2  UART TX mux owner: 0 arbiter, 1 loader, 2 dumper.
REQ-011 mem_sel_o  out  2  memory-port mux owner: 0 CPU, 1 loader, 2 dumper.
REQ-012 loader_grant_o  out  1  grant to loader unit.
REQ-013 loader_target_o  out  1  loader target select: 0 instruction memory, 1 data memory.
REQ-014 loader_done_i  in  1  loader finished; held until its grant drops.
REQ-015 dumper_grant_o  out  1  grant to memory-dump unit.
REQ-016 dumper_done_i  in  1  dumper finished; same protocol as loader_done_i.
REQ-017 cpu_stall_o  out  1  freezes the CPU pipeline when 1.

Function
REQ-018 Command bytes: LOAD_INSTR 0x1C, LOAD_DATA 0x1D, DUMP 0xD0, RUN 0xC0, STEP 0xC5, HALT 0xF0.
REQ-019 Reply bytes: ACK 0xA5, NACK 0xEE, TIMEOUT 0xE7.
REQ-020 States: S_IDLE, S_DECODE, S_SEND_REPLY, S_WAIT_TX, S_GRANT_LOADER, S_GRANT_DUMPER, S_RELEASE, S_RUN, S_STEP.
REQ-021 S_IDLE: cpu_stall_o=1, all grants 0, tx_sel_o=0, mem_sel_o=0; rx_ready_i latches rx_data_i into cmd register and moves to S_DECODE next cycle.
REQ-022 S_DECODE, one cycle: a known command selects ACK and records its post-reply target; an unknown byte selects NACK with target S_IDLE; then S_SEND_REPLY.
REQ-023 S_SEND_REPLY: tx_start_o=1 for exactly one cycle with tx_data_o = reply; then S_WAIT_TX.
REQ-024 tx_data_o holds its value from S_SEND_REPLY until tx_done_i.
REQ-025 S_WAIT_TX: stay until tx_done_i=1, then go to the recorded target.
REQ-026 Post-reply targets: LOAD_* -> S_GRANT_LOADER; DUMP -> S_GRANT_DUMPER; RUN -> S_RUN; STEP -> S_STEP; HALT -> S_IDLE.
REQ-027 S_GRANT_LOADER: loader_grant_o=1; loader_target_o = cmd[0], stable for the whole grant; tx_sel_o=1; mem_sel_o=1.
REQ-028 S_GRANT_DUMPER: dumper_grant_o=1, tx_sel_o=2, mem_sel_o=2.
REQ-029 While a grant is held, the arbiter ignores rx_ready_i; the bytes belong to the granted unit.
REQ-030 Grant release: the owner's done=1 drops the grant on the next edge and enters S_RELEASE.
REQ-031 S_RELEASE: keep the muxes on the owner and wait for done=0, then go to S_IDLE with muxes at 0.
REQ-032 Timeout: the counter clears on grant entry and increments each granted cycle.
REQ-033 When the counter reaches TIMEOUT_CYCLES-1 without done, the grant drops, TIMEOUT is replied via S_SEND_REPLY, and the target is S_IDLE.
REQ-034 If done and timeout coincide, done wins.
REQ-035 S_RUN: cpu_stall_o=0, mem_sel_o=0.
REQ-036 In S_RUN, only HALT is decoded: it sets cpu_stall_o=1 on the next edge and sends ACK; any other byte is discarded with no reply.
REQ-037 S_STEP: cpu_stall_o=0 for exactly one cycle, then ACK goes to S_IDLE via the reply path.
REQ-038 rx_ready_i arriving in S_DECODE, S_SEND_REPLY or S_WAIT_TX is dropped.

Reset
REQ-039 Asserting rst_ni at any time, including mid-grant, forces S_IDLE, with cpu_stall_o=1 and all other outputs 0.
REQ-040 Reset clears the cmd register, reply register and timeout counter to 0.
REQ-041 No reply byte is sent on reset exit.

Structure
REQ-042 A shared package host_pkg holds command/reply byte constants, the state enum, and the tx/mem owner encodings.
REQ-043 The timeout counter is the single sub-module, grant_watchdog, with inputs clear/enable and output expired.

Verification
REQ-044 Reset, then rx 0x1C -> 0xA5 transmitted, then loader_grant_o=1, loader_target_o=0, tx_sel_o=1, mem_sel_o=1.
REQ-045 During that grant, rx 0xF0 -> ignored; loader_done_i=1 -> grant 0 next edge; done 0 -> S_IDLE, muxes 0.
REQ-046 Rx 0x55 -> 0xEE transmitted, no grant, cpu_stall_o stays 1.
REQ-047 Rx 0xC0 -> ACK, then cpu_stall_o=0; rx 0xD0 -> no reply; rx 0xF0 -> cpu_stall_o=1, ACK.
REQ-048 With TIMEOUT_CYCLES=16, rx 0xD0 and dumper silent -> dumper_grant_o drops after 16 cycles, 0xE7 transmitted.
REQ-049 Rx 0xC5 -> cpu_stall_o low exactly 1 cycle; rst_ni pulse mid-loader-grant -> grant 0 immediately.
